carry_select_subtractor_pipe: RTL

Pipelined, block-segmented carry-select subtractor. It computes a - b - bin at a throughput of one operation per clock. The datapath is split into BLOCK-bit segments, one segment per pipeline stage. Each stage precomputes the difference for borrow-in 0 and for borrow-in 1, then selects the correct one using the borrow registered by the previous stage. The block sits in the arithmetic library beside the adders and uses valid/ready streaming on both sides.

---
 rtl/carry_select_subtractor_pipe_if.sv | 31 +++
 rtl/carry_select_subtractor_pipe.sv | 115 +++++++++++
 2 files changed

// File: rtl/carry_select_subtractor_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : carry_select_subtractor_pipe_if
// Purpose  : Valid/ready operand and result bundle for the pipelined subtractor.
// Revision : 1.0
// ============================================================================
interface carry_select_subtractor_pipe_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] diff;
    logic         bout;
    logic         ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/carry_select_subtractor_pipe.sv
`default_nettype none
// ============================================================================
// Module   : carry_select_subtractor_pipe
// Purpose  : Pipelined carry-select subtractor, one BLOCK-bit segment per stage.
// Revision : 1.0
// ============================================================================
module carry_select_subtractor_pipe #(
    parameter int N     = 8,
    parameter int BLOCK = 4
) (
    input  logic clk,
    input  logic rst,
    carry_select_subtractor_pipe_if.slave bus
);
    localparam int S = N / BLOCK;

    generate
        for (genvar k = 0; k < S; k++) begin : g_stage
            localparam int SRC_W  = N - k * BLOCK;
            localparam int DONE_W = (k + 1) * BLOCK;

            logic              r_valid;
            logic              r_brw;
            logic              r_amsb;
            logic              r_bmsb;
            logic [DONE_W-1:0] r_diff;

            logic              w_ready;
            logic              w_ready_next;
            logic              w_src_valid;
            logic              w_src_brw;
            logic              w_src_amsb;
            logic              w_src_bmsb;
            logic [SRC_W-1:0]  w_src_a;
            logic [SRC_W-1:0]  w_src_b;
            logic [DONE_W-1:0] w_next_diff;
            logic [BLOCK:0]    w_d0;
            logic [BLOCK:0]    w_d1;
            logic [BLOCK:0]    w_sel;

            if (k == 0) begin : g_head
                assign w_src_valid = bus.in_valid;
                assign w_src_brw   = bus.bin;
                assign w_src_amsb  = bus.a[N-1];
                assign w_src_bmsb  = bus.b[N-1];
                assign w_src_a     = bus.a;
                assign w_src_b     = bus.b;
                assign w_next_diff = w_sel[BLOCK-1:0];
            end else begin : g_body
                assign w_src_valid = g_stage[k-1].r_valid;
                assign w_src_brw   = g_stage[k-1].r_brw;
                assign w_src_amsb  = g_stage[k-1].r_amsb;
                assign w_src_bmsb  = g_stage[k-1].r_bmsb;
                assign w_src_a     = g_stage[k-1].g_rem.r_a_rem;
                assign w_src_b     = g_stage[k-1].g_rem.r_b_rem;
                assign w_next_diff = {w_sel[BLOCK-1:0], g_stage[k-1].r_diff};
            end

            if (k == S - 1) begin : g_tail
                assign w_ready_next = bus.out_ready;
            end else begin : g_link
                assign w_ready_next = g_stage[k+1].w_ready;
            end

            // Both borrow-in cases are formed up front; the registered borrow only picks one.
            assign w_d0    = {1'b0, w_src_a[BLOCK-1:0]} - {1'b0, w_src_b[BLOCK-1:0]};
            assign w_d1    = {1'b0, w_src_a[BLOCK-1:0]} - {1'b0, w_src_b[BLOCK-1:0]}
                             - (BLOCK + 1)'(1);
            assign w_sel   = w_src_brw ? w_d1 : w_d0;
            assign w_ready = !r_valid | w_ready_next;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_brw   <= 1'b0;
                    r_amsb  <= 1'b0;
                    r_bmsb  <= 1'b0;
                    r_diff  <= '0;
                end else if (w_ready) begin
                    r_valid <= w_src_valid;
                    if (w_src_valid) begin
                        r_brw  <= w_sel[BLOCK];
                        r_amsb <= w_src_amsb;
                        r_bmsb <= w_src_bmsb;
                        r_diff <= w_next_diff;
                    end
                end
            end

            // Operand bits not yet consumed travel with the operation.
            if (SRC_W > BLOCK) begin : g_rem
                logic [SRC_W-BLOCK-1:0] r_a_rem;
                logic [SRC_W-BLOCK-1:0] r_b_rem;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_a_rem <= '0;
                        r_b_rem <= '0;
                    end else if (w_ready && w_src_valid) begin
                        r_a_rem <= w_src_a[SRC_W-1:BLOCK];
                        r_b_rem <= w_src_b[SRC_W-1:BLOCK];
                    end
                end
            end
        end
    endgenerate

    assign bus.in_ready  = g_stage[0].w_ready;
    assign bus.out_valid = g_stage[S-1].r_valid;
    assign bus.diff      = g_stage[S-1].r_diff;
    assign bus.bout      = g_stage[S-1].r_brw;
    assign bus.ovf       = (g_stage[S-1].r_amsb != g_stage[S-1].r_bmsb)
                         & (g_stage[S-1].r_diff[N-1] != g_stage[S-1].r_amsb);
endmodule
`default_nettype wire
